// File: rtl/lsu_dcache_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_dcache_arbiter
//
// Merges the load/store unit's D$ request ports (0: PTW, 1: load, 2: store)
// onto a single memory port. Arbitration is round-robin and combinational.
// When the memory stalls a request, the arbiter locks onto that port so the
// memory sees a stable request until it is accepted. The port ID of every
// granted request goes into an in-order ID FIFO, which routes each in-order
// memory response back to the port that issued it.
//
// Ports
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   req_i/we_i         per-port request valid / write enable
//   addr_i/wdata_i/be_i  per-port payload, port p at [p*W +: W]
//   gnt_o              one-hot grant back to the requesting port
//   rvalid_o, rdata_o  one-hot response valid; response data shared by all ports
//   mem_req_o ... mem_be_o   request towards memory (payload is 0 when idle)
//   mem_gnt_i          memory accepts the presented request this cycle
//   mem_rvalid_i/mem_rdata_i  in-order memory responses
//   resp_err_o         sticky: a response arrived while nothing was outstanding
// ---------------------------------------------------------------------------
module lsu_dcache_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int ADDR_W   = 56,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NR_PORTS-1:0]          req_i,
    input  logic [NR_PORTS-1:0]          we_i,
    input  logic [NR_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [NR_PORTS*DATA_W-1:0]   wdata_i,
    input  logic [NR_PORTS*DATA_W/8-1:0] be_i,
    output logic [NR_PORTS-1:0]          gnt_o,
    output logic [NR_PORTS-1:0]          rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic [DATA_W/8-1:0]          mem_be_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         resp_err_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = AW + 1;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   lock_id_reg, lock_id_next;
    logic [PW-1:0]   rr_reg, rr_next;
    logic [PW-1:0]   sel_rr;
    logic [PW-1:0]   sel;
    logic            mem_req;
    logic            grant;

    // ID FIFO
    logic [PW-1:0]   id_mem [DEPTH];
    logic [AW-1:0]   wptr_reg, rptr_reg;
    logic [CW-1:0]   count_reg;
    logic            err_reg;
    logic            full, empty, push, pop;
    logic [PW-1:0]   head;

    logic [NR_PORTS-1:0] eligible;

    // Per-port payload unpacked into arrays so the mux below is a plain index.
    logic [ADDR_W-1:0] addr_arr  [NR_PORTS];
    logic [DATA_W-1:0] wdata_arr [NR_PORTS];
    logic [BE_W-1:0]   be_arr    [NR_PORTS];

    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
        assign be_arr[gi]    = be_i[gi*BE_W +: BE_W];
    end

    // Full is judged on the registered count, so a pop this cycle does not
    // open a slot until the next cycle.
    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign eligible = req_i & ~{NR_PORTS{full}};

    // Round-robin pick: scan offsets from the far end down so the closest
    // eligible port at or after rr_reg is the last (winning) assignment.
    always_comb begin
        sel_rr = rr_reg;
        for (int k = NR_PORTS - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_reg) + k) % NR_PORTS]) begin
                sel_rr = PW'((int'(rr_reg) + k) % NR_PORTS);
            end
        end
    end

    // Lock FSM: next-state, selection and round-robin update.
    always_comb begin
        state_next   = state_reg;
        lock_id_next = lock_id_reg;
        rr_next      = rr_reg;
        sel          = sel_rr;
        mem_req      = |eligible;

        case (state_reg)
            ST_ARB: begin
                sel     = sel_rr;
                mem_req = |eligible;
            end
            ST_LOCKED: begin
                // The locked requester is still holding its request; it is
                // only masked while the ID FIFO has no room.
                sel     = lock_id_reg;
                mem_req = ~full;
            end
            default: begin
                sel     = sel_rr;
                mem_req = |eligible;
            end
        endcase

        if (mem_req && !mem_gnt_i) begin
            state_next   = ST_LOCKED;
            lock_id_next = sel;
        end else if (mem_req) begin
            state_next = ST_ARB;
            rr_next    = (int'(sel) == NR_PORTS - 1) ? '0 : sel + PW'(1);
        end
    end

    assign grant = mem_req & mem_gnt_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_ARB;
            lock_id_reg <= '0;
            rr_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            lock_id_reg <= lock_id_next;
            rr_reg      <= rr_next;
        end
    end

    // Request side outputs; payload forced to 0 whenever nothing is presented.
    assign mem_req_o   = mem_req;
    assign mem_we_o    = mem_req & we_i[sel];
    assign mem_addr_o  = mem_req ? addr_arr[sel]  : '0;
    assign mem_wdata_o = mem_req ? wdata_arr[sel] : '0;
    assign mem_be_o    = mem_req ? be_arr[sel]    : '0;
    assign gnt_o       = grant ? (NR_PORTS'(1) << sel) : '0;

    // ID FIFO. A response with nothing outstanding is flagged, not popped.
    assign push = grant;
    assign pop  = mem_rvalid_i & ~empty;

    // The storage is a handful of bits and the response must be routed in
    // the same cycle, so the head is read combinationally.
    assign head = id_mem[rptr_reg];

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wptr_reg] <= sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (mem_rvalid_i && empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign rvalid_o   = pop ? (NR_PORTS'(1) << head) : '0;
    assign rdata_o    = mem_rdata_i;
    assign resp_err_o = err_reg;

endmodule
